// File: rtl/cpu_pkg.sv
// Machine-wide constants of the 19-bit CPU, shared by fetch, the IF/ID queue and decode.
package cpu_pkg;
  localparam int                 INSTR_W   = 19;
  localparam int                 PC_W      = 8;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 19'h00000;
endpackage

// File: rtl/if_id_queue_pkg.sv
// Sizing helpers for the IF/ID queue; keeps pointer/count widths consistent between the queue and its interface.
package if_id_queue_pkg;
  localparam int DEFAULT_DEPTH = 2;

  // A 1-entry queue still carries a 1-bit pointer so the storage index is never zero width.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-side push handshake, decode-side pop handshake, flush and occupancy of the IF/ID queue.
interface if_id_queue_if #(
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int DEPTH   = if_id_queue_pkg::DEFAULT_DEPTH
);
  localparam int CNT_W = if_id_queue_pkg::cnt_width(DEPTH);

  logic               flush;
  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instruction;
  logic [PC_W-1:0]    if_pc_plus_one;
  logic               id_valid;
  logic               id_ready;
  logic [INSTR_W-1:0] id_instruction;
  logic [PC_W-1:0]    id_pc_plus_one;
  logic [CNT_W-1:0]   count;

  modport slave (
    input  flush, if_valid, if_instruction, if_pc_plus_one, id_ready,
    output if_ready, id_valid, id_instruction, id_pc_plus_one, count
  );

  modport master (
    output flush, if_valid, if_instruction, if_pc_plus_one, id_ready,
    input  if_ready, id_valid, id_instruction, id_pc_plus_one, count
  );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID circular queue: lets fetch run up to DEPTH entries ahead of a stalled decode; flush empties it on redirect.
module if_id_queue
  import cpu_pkg::*;
  import if_id_queue_pkg::*;
#(
  parameter int                 INSTR_W   = cpu_pkg::INSTR_W,
  parameter int                 PC_W      = cpu_pkg::PC_W,
  parameter int                 DEPTH     = if_id_queue_pkg::DEFAULT_DEPTH,
  parameter logic [INSTR_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  if_id_queue_if.slave q
);
  localparam int               PTR_W = ptr_width(DEPTH);
  localparam int               CNT_W = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

  logic [DEPTH-1:0][INSTR_W-1:0] instr_q, instr_d;
  logic [DEPTH-1:0][PC_W-1:0]    pc_q, pc_d;
  logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic                          if_ready, id_valid, push, pop;

  // Depth need not be a power of two, so wrap explicitly instead of relying on overflow.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Ready looks only at occupancy: a full queue refuses even when decode pops that cycle.
  assign if_ready = (count_q != FULL);
  assign id_valid = (count_q != '0);
  assign push     = q.if_valid & if_ready;
  assign pop      = id_valid & q.id_ready;

  assign q.if_ready       = if_ready;
  assign q.id_valid       = id_valid;
  assign q.count          = count_q;
  assign q.id_instruction = id_valid ? instr_q[rd_ptr_q] : NOP_INSTR;
  assign q.id_pc_plus_one = id_valid ? pc_q[rd_ptr_q] : '0;

  always_comb begin
    instr_d  = instr_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        instr_d[wr_ptr_q] = q.if_instruction;
        pc_d[wr_ptr_q]    = q.if_pc_plus_one;
        wr_ptr_d          = wrap_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = wrap_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is never reset; stale contents are masked by count.
  always_ff @(posedge clk) begin
    instr_q <= instr_d;
    pc_q    <= pc_d;
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      assert (count_q <= FULL);
      assert (!(push && count_q == FULL));
      assert (!(pop && count_q == '0));
    end
  end
`endif
endmodule
